seq_mult: RTL and testbench

- Parametrised sequential shift-add multiplier: control FSM plus datapath in one block.
- Successor to the fixed-width 4-state multiplier controller.
- Adds a WIDTH parameter, signed/unsigned mode, and a start/busy/done handshake.
- Adds early termination and a single-cycle add+shift step.
- Sits beside the ALU in the example system as a multi-cycle arithmetic unit.

---
 rtl/seq_mult_pkg.sv | 11 +
 rtl/seq_mult_if.sv | 22 ++
 rtl/seq_mult_ctrl.sv | 52 +++++
 rtl/seq_mult.sv | 79 +++++++
 tb/tb_seq_mult.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// State encoding is fixed so that the unused code 2'b11 is recoverable.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_mult_if.sv
// Request/response bundle between a client and the sequential multiplier.
interface seq_mult_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       op_a;
  logic [WIDTH-1:0]       op_b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, signed_mode, op_a, op_b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, op_a, op_b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the shift-add multiplier; issues load/step/finish strobes.
//   state  | meaning
//   S_IDLE | waiting for start; operands latched on accept
//   S_CALC | one add+shift per edge until the multiplier is exhausted
//   S_FIN  | apply sign, publish product, pulse done
module seq_mult_ctrl
  import seq_mult_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic b_zero_next,
  output logic load,
  output logic step,
  output logic finish,
  output logic busy
);

  state_t r_state;
  state_t w_state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = S_IDLE;
    load         = 1'b0;
    step         = 1'b0;
    finish       = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          load         = 1'b1;
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        step         = 1'b1;
        w_state_next = b_zero_next ? S_FIN : S_CALC;
      end
      S_FIN: begin
        finish       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: signed/unsigned, early termination,
// one add+shift per cycle. Operates on magnitudes and re-applies the sign.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         reset,
  seq_mult_if.slave   bus
);

  localparam int PW = 2 * WIDTH;

  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic             w_busy;
  logic             w_b_zero_next;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_neg;

  logic [PW-1:0]    r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_acc;
  logic             r_neg;
  logic [PW-1:0]    r_product;
  logic             r_done;

  // Negating the most negative value wraps back to itself, which read as
  // unsigned is exactly its magnitude.
  assign w_mag_a = (bus.signed_mode && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign w_mag_b = (bus.signed_mode && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
  assign w_neg   = bus.signed_mode & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);

  assign w_b_zero_next = ((r_b >> 1) == '0);

  seq_mult_ctrl u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .start       (bus.start),
    .b_zero_next (w_b_zero_next),
    .load        (w_load),
    .step        (w_step),
    .finish      (w_finish),
    .busy        (w_busy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_a   <= {{WIDTH{1'b0}}, w_mag_a};
        r_b   <= w_mag_b;
        r_acc <= '0;
        r_neg <= w_neg;
      end
      if (w_step) begin
        if (r_b[0]) r_acc <= r_acc + r_a;
        r_a <= r_a << 1;
        r_b <= r_b >> 1;
      end
      if (w_finish) r_product <= r_neg ? -r_acc : r_acc;
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult (WIDTH=8): vector table plus handshake,
// reset and back-to-back sequences.
module tb_seq_mult;

  logic clk = 1'b0;
  logic reset;

  seq_mult_if #(.WIDTH(8)) bus ();

  seq_mult #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] prod;
    int          lat;   // edges from the accepting edge to the edge after which done is high (n+1)
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called mid-cycle (#1 after an edge); returns mid-cycle in the done cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input bit poke, output logic [15:0] prod, output int lat,
                        output bit hs_ok, output bit hold_ok);
    logic [15:0] held;
    held    = bus.product;
    prod    = 16'hxxxx;
    lat     = -1;
    hs_ok   = 1'b1;
    hold_ok = 1'b1;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.signed_mode = sm;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (!bus.busy || bus.done) hs_ok = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (poke && k == 1) begin
        bus.start       = 1'b1;
        bus.op_a        = 8'h03;
        bus.op_b        = 8'h03;
        bus.signed_mode = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        lat  = k;
        prod = bus.product;
        if (bus.busy) hs_ok = 1'b0;
        break;
      end
      if (!bus.busy) hs_ok = 1'b0;
      if (bus.product !== held) hold_ok = 1'b0;
    end
  endtask

  logic [15:0] prod;
  int          lat;
  bit          hs_ok;
  bit          hold_ok;
  bit          no_done;

  initial begin
    vecs[0]  = '{8'd13,  8'd11,  1'b0, 16'h008F, 5};
    vecs[1]  = '{8'hFD,  8'd5,   1'b1, 16'hFFF1, 4};
    vecs[2]  = '{8'h80,  8'h80,  1'b1, 16'h4000, 9};
    vecs[3]  = '{8'hFF,  8'hFF,  1'b0, 16'hFE01, 9};
    vecs[4]  = '{8'd200, 8'd0,   1'b0, 16'h0000, 2};
    vecs[5]  = '{8'd7,   8'd6,   1'b0, 16'h002A, 4};
    vecs[6]  = '{8'hFF,  8'hFF,  1'b1, 16'h0001, 2};
    vecs[7]  = '{8'h00,  8'hFB,  1'b1, 16'h0000, 4};
    vecs[8]  = '{8'h7F,  8'h80,  1'b1, 16'hC080, 9};
    vecs[9]  = '{8'h80,  8'h02,  1'b0, 16'h0100, 3};
    vecs[10] = '{8'h05,  8'hFF,  1'b1, 16'hFFFB, 2};
    vecs[11] = '{8'hFD,  8'h05,  1'b0, 16'h04F1, 4};

    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    #12;
    chk("reset busy",    {31'd0, bus.busy}, 32'd0);
    chk("reset done",    {31'd0, bus.done}, 32'd0);
    chk("reset product", {16'd0, bus.product}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, 1'b0, prod, lat, hs_ok, hold_ok);
      chk($sformatf("v%0d product", i), {16'd0, prod}, {16'd0, vecs[i].prod});
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d handshake", i), {31'd0, hs_ok}, 32'd1);
      chk($sformatf("v%0d hold", i), {31'd0, hold_ok}, 32'd1);
    end

    // start pulsed while busy must be ignored
    run_op(8'd13, 8'd11, 1'b0, 1'b1, prod, lat, hs_ok, hold_ok);
    chk("poke product", {16'd0, prod}, 32'h008F);
    chk("poke latency", lat, 5);
    chk("poke handshake", {31'd0, hs_ok}, 32'd1);

    // back-to-back: second start issued in the first done cycle
    run_op(8'd13, 8'd11, 1'b0, 1'b0, prod, lat, hs_ok, hold_ok);
    chk("b2b first product", {16'd0, prod}, 32'h008F);
    run_op(8'd7, 8'd6, 1'b0, 1'b0, prod, lat, hs_ok, hold_ok);
    chk("b2b second product", {16'd0, prod}, 32'h002A);
    chk("b2b second latency", lat, 4);
    chk("b2b done drop", {31'd0, hs_ok}, 32'd1);
    chk("b2b first held", {31'd0, hold_ok}, 32'd1);

    // async reset during the second CALC cycle
    bus.op_a        = 8'd13;
    bus.op_b        = 8'd11;
    bus.signed_mode = 1'b0;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset busy", {31'd0, bus.busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midop reset busy",    {31'd0, bus.busy}, 32'd0);
    chk("midop reset done",    {31'd0, bus.done}, 32'd0);
    chk("midop reset product", {16'd0, bus.product}, 32'd0);
    #1 reset = 1'b0;
    no_done = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) no_done = 1'b0;
    end
    chk("no done after reset", {31'd0, no_done}, 32'd1);
    run_op(8'd13, 8'd11, 1'b0, 1'b0, prod, lat, hs_ok, hold_ok);
    chk("post-reset product", {16'd0, prod}, 32'h008F);
    chk("post-reset latency", lat, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
